axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter DATA_W, 16, data bus width in bits; legal values 16, 32 or 64.
REQ-002 Parameter ADDR_W, 8, byte-address width.
REQ-003 Parameter DEPTH, 64, memory depth in DATA_W words; DEPTH*DATA_W/8 SHALL NOT exceed 2^ADDR_W.
REQ-004 Port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 Port res_n, input, 1, asynchronous active-low reset.
REQ-006 Ports awvalid/awready, in/out, 1 each, write-address handshake.
REQ-007 Ports awaddr, awlen, awsize, awburst, in, ADDR_W/4/3/2, write burst address, beats-1, log2 bytes per beat, type.
REQ-008 Ports wvalid/wready, in/out, 1 each, write-data handshake.
REQ-009 Ports wdata, wstrb, wlast, in, DATA_W/DATA_W/8/1, write data, byte enables, final beat.
REQ-010 Ports bvalid/bready, out/in, 1 each; bresp, out, 2, write response.
REQ-011 Ports arvalid/arready, out for arready, 1 each; araddr, arlen, arsize, arburst, in, as REQ-007 for reads.
REQ-012 Ports rvalid/rready, out/in, 1 each; rdata, out, DATA_W; rresp, out, 2; rlast, out, 1.

Function
REQ-013 One FSM with states IDLE, WDATA, WRESP and RDATA; only one burst in flight.
REQ-014 In IDLE, awready=arready=1; when awvalid and arvalid rise together, the channel not served last wins (round-robin), with write first after reset, and the other ready drops that cycle.
REQ-015 An accepted AW SHALL latch address, len, size and burst, then move to WDATA with wready=1 on the next cycle.
REQ-016 Each wvalid&&wready beat SHALL write the enabled bytes of the current word, then advance the address.
REQ-017 A wlast beat SHALL end WDATA and move to WRESP; bvalid SHALL rise the next cycle and hold until bready, then return to IDLE.
REQ-018 An accepted AR SHALL move to RDATA with rvalid=1 on the next cycle; the first-beat latency SHALL be exactly 1 cycle.
REQ-019 rdata, rresp and rlast SHALL stay stable while rvalid&&!rready; the address advances only on rvalid&&rready.
REQ-020 rlast SHALL be 1 on beat awlen/arlen; rvalid&&rready&&rlast SHALL return to IDLE.
REQ-021 Burst addressing SHALL follow these rules: FIXED (00) holds the address; INCR (01) adds 2^size; WRAP (10) adds 2^size inside a block of (len+1)*2^size aligned to that size.
REQ-022 Word index SHALL be addr >> log2(DATA_W/8); narrow beats use byte lanes addr[log2(DATA_W/8)-1:0] only.
REQ-023 bresp/rresp SHALL be SLVERR (10) for any of these conditions, otherwise OKAY (00):
- burst=11;
- 2^size > DATA_W/8;
- WRAP with len not in {1,3,7,15};
- byte address >= DEPTH*DATA_W/8.
REQ-024 Beats flagged SLVERR SHALL NOT modify memory, and their reads SHALL return rdata=0.
REQ-025 bresp SHALL be SLVERR if any beat errored or wlast arrived on a beat other than beat awlen; surplus beats after awlen without wlast SHALL be accepted and discarded.
REQ-026 The beat counter SHALL be 4 bits; address arithmetic SHALL be ADDR_W bits and wrap modulo 2^ADDR_W for INCR.

Reset
REQ-027 While res_n=0, the FSM SHALL be in IDLE, and awready, arready, wready, bvalid, rvalid and rlast SHALL be 0, with bresp, rresp and rdata 0.
REQ-028 Deassertion SHALL take effect at the next clk edge; a burst in progress SHALL be abandoned, with no response issued.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package axi_pkg SHALL hold burst encodings (FIXED/INCR/WRAP), response encodings (OKAY/SLVERR), the FSM state type and the next-address function.
REQ-031 The memory array SHALL be sub-module axi_mem_bank, with a byte-enabled synchronous write and a combinational read, parameterised by DATA_W and DEPTH.

Verification
REQ-032 Verification SHALL cover these directed scenarios on the default configuration:
- INCR write, awaddr=0, len=3, size=1, data ff11/11aa/0011/1110, then INCR read of the same range -> four beats returning the same values, rlast on beat 3, OKAY.
- WRAP read with araddr=0x06, len=3, size=1 -> word indices 3,0,1,2.
- Simultaneous awvalid and arvalid after reset -> write served first, read served next.
- Reads with arsize=2 -> all beats SLVERR with rdata 0; araddr=0x80 -> SLVERR.
- rready toggling 1,0,0,1 during a read -> data held while stalled, no beat lost.
- res_n pulsed low mid-write -> outputs zero and FSM in IDLE, with the locations written before reset retaining their data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, the FSM state type and the burst address helpers
// used by the memory-mapped slave.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WDATA = 2'b01,
        ST_WRESP = 2'b10,
        ST_RDATA = 2'b11
    } axi_state_t;

    // Computed at 64 bits; callers truncate to their own address width,
    // which gives the modulo wrap for INCR.
    function automatic logic [63:0] axi_next_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [3:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        logic [63:0] wrap_mask;
        step      = 64'd1 << size;
        wrap_mask = (({60'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_INCR: return addr + step;
            BURST_WRAP: return (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    return addr;
        endcase
    endfunction

    function automatic logic axi_burst_err(
        input logic [1:0] burst,
        input logic [2:0] size,
        input logic [3:0] len,
        input logic [2:0] max_size
    );
        logic bad_wrap_len;
        bad_wrap_len = !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
        return (burst == BURST_RSVD) || (size > max_size) ||
               ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

endpackage

// File: rtl/axi_mem_bank.sv
// Word-organised memory with byte-enabled synchronous write and an
// asynchronous read port; contents are never reset.
module axi_mem_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: one burst in flight, round-robin AW/AR arbitration,
// FIXED/INCR/WRAP addressing and SLVERR for illegal or out-of-range beats.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [3:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [3:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(DEPTH * NB);

    axi_state_t        r_state;
    logic              r_idle_rdy;
    logic              r_last_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [3:0]        r_beat;
    logic              r_burst_err;
    logic              r_wr_err;
    logic              r_over;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic              r_rlast;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_both;
    logic              w_awready;
    logic              w_arready;
    logic              w_aw_hs;
    logic              w_ar_hs;
    logic              w_w_hs;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_burst_err;
    logic              w_rd_err;
    logic              w_wr_err;
    logic              w_we;
    logic [LB-1:0]     w_lane;
    logic [NB-1:0]     w_lane_en;
    logic [NB-1:0]     w_be;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_mem_rdata;

    // On a tie the channel not served last wins; r_last_wr resets to 0 so writes go first.
    assign w_both    = awvalid && arvalid;
    assign w_awready = r_idle_rdy && !(w_both && r_last_wr);
    assign w_arready = r_idle_rdy && !(w_both && !r_last_wr);
    assign w_aw_hs   = awvalid && w_awready;
    assign w_ar_hs   = arvalid && w_arready;
    assign w_w_hs    = wvalid && r_wready;

    assign w_next_addr = ADDR_W'(axi_next_addr(64'(r_addr), r_size, r_len, r_burst));

    // The read port looks one beat ahead so rdata can be registered with no bubble.
    assign w_rd_addr      = (r_state == ST_RDATA) ? w_next_addr : araddr;
    assign w_rd_burst_err = (r_state == ST_RDATA) ? r_burst_err
                                                  : axi_burst_err(arburst, arsize, arlen, 3'(LB));
    assign w_rd_err       = w_rd_burst_err || ({1'b0, w_rd_addr} >= MEM_LIMIT);
    assign w_rd_idx       = IDX_W'(w_rd_addr >> LB);

    assign w_wr_err = r_burst_err || ({1'b0, r_addr} >= MEM_LIMIT);
    assign w_wr_idx = IDX_W'(r_addr >> LB);
    assign w_lane   = r_addr[LB-1:0];

    // Narrow beats touch only the lanes from the address up to its size boundary.
    always_comb begin
        w_lane_en = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(w_lane)) && ((i >> r_size) == (int'(w_lane) >> r_size))) begin
                w_lane_en[i] = 1'b1;
            end
        end
    end

    assign w_be = wstrb & w_lane_en;
    assign w_we = w_w_hs && !w_wr_err && !r_over;

    axi_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (w_wr_idx),
        .i_wdata (wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= ST_IDLE;
            r_idle_rdy  <= 1'b0;
            r_last_wr   <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_burst_err <= 1'b0;
            r_wr_err    <= 1'b0;
            r_over      <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idle_rdy <= 1'b1;
                    if (w_aw_hs) begin
                        r_state     <= ST_WDATA;
                        r_idle_rdy  <= 1'b0;
                        r_last_wr   <= 1'b1;
                        r_addr      <= awaddr;
                        r_len       <= awlen;
                        r_size      <= awsize;
                        r_burst     <= awburst;
                        r_beat      <= '0;
                        r_burst_err <= axi_burst_err(awburst, awsize, awlen, 3'(LB));
                        r_wr_err    <= 1'b0;
                        r_over      <= 1'b0;
                        r_wready    <= 1'b1;
                    end else if (w_ar_hs) begin
                        r_state     <= ST_RDATA;
                        r_idle_rdy  <= 1'b0;
                        r_last_wr   <= 1'b0;
                        r_addr      <= araddr;
                        r_len       <= arlen;
                        r_size      <= arsize;
                        r_burst     <= arburst;
                        r_beat      <= '0;
                        r_burst_err <= w_rd_burst_err;
                        r_rvalid    <= 1'b1;
                        r_rdata     <= w_rd_err ? '0 : w_mem_rdata;
                        r_rresp     <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_rlast     <= (arlen == 4'd0);
                    end
                end
                ST_WDATA: begin
                    if (w_w_hs) begin
                        r_addr <= w_next_addr;
                        r_beat <= r_beat + 4'd1;
                        if (w_wr_err && !r_over) begin
                            r_wr_err <= 1'b1;
                        end
                        if (r_beat == r_len) begin
                            r_over <= 1'b1;
                        end
                        if (wlast) begin
                            r_state  <= ST_WRESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_wr_err || (w_wr_err && !r_over) || r_over ||
                                         (r_beat != r_len)) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bready) begin
                        r_state    <= ST_IDLE;
                        r_bvalid   <= 1'b0;
                        r_idle_rdy <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (rready) begin
                        if (r_rlast) begin
                            r_state    <= ST_IDLE;
                            r_rvalid   <= 1'b0;
                            r_rlast    <= 1'b0;
                            r_idle_rdy <= 1'b1;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_beat  <= r_beat + 4'd1;
                            r_rdata <= w_rd_err ? '0 : w_mem_rdata;
                            r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                            r_rlast <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_idle_rdy <= 1'b0;
                end
            endcase
        end
    end

    assign awready = w_awready;
    assign arready = w_arready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave in its default configuration.
`timescale 1ns/1ps
module tb_axi_mem_slave;
    import axi_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;

    localparam logic [15:0] PAT     [4] = '{16'hff11, 16'h11aa, 16'h0011, 16'h1110};
    localparam logic [15:0] WRAP_D  [4] = '{16'h1110, 16'hff11, 16'h11aa, 16'h0011};
    localparam logic [15:0] STALL_D [6] = '{16'hff11, 16'h11aa, 16'h11aa, 16'h11aa, 16'h0011, 16'h1110};
    localparam logic        STALL_R [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic        STALL_L [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic              clk = 1'b0;
    logic              res_n = 1'b0;
    logic              awvalid = 1'b0, awready;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [3:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              wvalid = 1'b0, wready;
    logic [DATA_W-1:0] wdata = '0;
    logic [1:0]        wstrb = '0;
    logic              wlast = 1'b0;
    logic              bvalid, bready = 1'b0;
    logic [1:0]        bresp;
    logic              arvalid = 1'b0, arready;
    logic [ADDR_W-1:0] araddr = '0;
    logic [3:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              rvalid, rready = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .res_n(res_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake drivers: start and end 1 ns after a rising edge, bounded to 20 cycles.
    task automatic aw_req(input logic [7:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, output bit ok);
        awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (awready) ok = 1'b1;
            tick();
        end
        awvalid = 1'b0;
    endtask

    task automatic ar_req(input logic [7:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, output bit ok);
        araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1'b1;
            tick();
        end
        arvalid = 1'b0;
    endtask

    task automatic w_send(input logic [15:0] d, input logic [1:0] st, input logic last,
                          output bit ok);
        wdata = d; wstrb = st; wlast = last; wvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (wready) ok = 1'b1;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_take(output logic [1:0] resp, output bit ok);
        bready = 1'b1; ok = 1'b0; resp = 2'bxx;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; resp = bresp; end
            tick();
        end
        bready = 1'b0;
    endtask

    task automatic r_take(output logic [15:0] d, output logic [1:0] resp, output logic last,
                          output bit ok);
        rready = 1'b1; ok = 1'b0; d = 'x; resp = 2'bxx; last = 1'bx;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1'b1; d = rdata; resp = rresp; last = rlast; end
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0)
            begin failures++; $display("FAIL reset_ctrl: got %b required 000000",
                {awready, arready, wready, bvalid, rvalid, rlast}); end
        checks++;
        if ({bresp, rresp, rdata} !== 20'h0)
            begin failures++; $display("FAIL reset_data: bresp=%0d rresp=%0d rdata=%h required 0", bresp, rresp, rdata); end
        checks++;
        if (dut.r_state !== ST_IDLE)
            begin failures++; $display("FAIL reset_state: got %0d required IDLE", dut.r_state); end
        tick();
        res_n = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0)
            begin failures++; $display("FAIL reset_release_same_cycle: awready=%b required 0", awready); end
        tick();
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1)
            begin failures++; $display("FAIL reset_release_edge: awready=%b arready=%b required 1 1", awready, arready); end
    endtask

    task automatic test_incr_write_read();
        bit ok, hs;
        logic [1:0] resp;
        logic [15:0] d;
        logic l;
        hs = 1'b1;
        aw_req(8'h00, 4'd3, 3'd1, BURST_INCR, ok); hs &= ok;
        checks++;
        if (wready !== 1'b1) begin failures++; $display("FAIL wready_after_aw: got %b required 1", wready); end
        for (int i = 0; i < 4; i++) begin
            w_send(PAT[i], 2'b11, (i == 3), ok); hs &= ok;
        end
        checks++;
        if (bvalid !== 1'b1 || wready !== 1'b0)
            begin failures++; $display("FAIL bvalid_after_wlast: bvalid=%b wready=%b required 1 0", bvalid, wready); end
        b_take(resp, ok); hs &= ok;
        checks++;
        if (resp !== RESP_OKAY) begin failures++; $display("FAIL incr_bresp: got %0d required 0", resp); end
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_idle: got %b required 0", rvalid); end
        ar_req(8'h00, 4'd3, 3'd1, BURST_INCR, ok); hs &= ok;
        checks++;
        if (rvalid !== 1'b1 || rdata !== PAT[0])
            begin failures++; $display("FAIL first_beat_latency: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, PAT[0]); end
        for (int i = 0; i < 4; i++) begin
            r_take(d, resp, l, ok); hs &= ok;
            checks++;
            if (d !== PAT[i] || resp !== RESP_OKAY || l !== (i == 3))
                begin failures++; $display("FAIL incr_read beat %0d: data=%h resp=%0d last=%b required %h 0 %b",
                    i, d, resp, l, PAT[i], (i == 3)); end
        end
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1)
            begin failures++; $display("FAIL incr_read_end: rvalid=%b arready=%b required 0 1", rvalid, arready); end
        checks++;
        if (!hs) begin failures++; $display("FAIL incr_handshake: completed=0 required 1"); end
    endtask

    task automatic test_wrap_fixed();
        bit ok, hs;
        logic [1:0] resp;
        logic [15:0] d;
        logic l;
        hs = 1'b1;
        ar_req(8'h06, 4'd3, 3'd1, BURST_WRAP, ok); hs &= ok;
        for (int i = 0; i < 4; i++) begin
            r_take(d, resp, l, ok); hs &= ok;
            checks++;
            if (d !== WRAP_D[i] || resp !== RESP_OKAY || l !== (i == 3))
                begin failures++; $display("FAIL wrap_read beat %0d: data=%h resp=%0d last=%b required %h 0 %b",
                    i, d, resp, l, WRAP_D[i], (i == 3)); end
        end
        ar_req(8'h02, 4'd1, 3'd1, BURST_FIXED, ok); hs &= ok;
        for (int i = 0; i < 2; i++) begin
            r_take(d, resp, l, ok); hs &= ok;
            checks++;
            if (d !== 16'h11aa || resp !== RESP_OKAY)
                begin failures++; $display("FAIL fixed_read beat %0d: data=%h resp=%0d required 11aa 0", i, d, resp); end
        end
        checks++;
        if (!hs) begin failures++; $display("FAIL wrap_handshake: completed=0 required 1"); end
    endtask

    task automatic test_arbitration();
        bit ok, hs;
        logic [1:0] resp;
        hs = 1'b1;
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        tick();
        awaddr = 8'h10; awlen = 4'd0; awsize = 3'd1; awburst = BURST_INCR;
        araddr = 8'h10; arlen = 4'd0; arsize = 3'd1; arburst = BURST_INCR;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b0)
            begin failures++; $display("FAIL arb_write_first: awready=%b arready=%b required 1 0", awready, arready); end
        tick();
        awvalid = 1'b0;
        w_send(16'hbeef, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin failures++; $display("FAIL arb_read_next: arready=%b required 1", arready); end
        tick();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'hbeef || rlast !== 1'b1)
            begin failures++; $display("FAIL arb_read_data: rvalid=%b rdata=%h rlast=%b required 1 beef 1", rvalid, rdata, rlast); end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b0)
            begin failures++; $display("FAIL arb_round_robin: awready=%b arready=%b required 1 0", awready, arready); end
        tick();
        awvalid = 1'b0;
        arvalid = 1'b0;
        w_send(16'hbeef, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        checks++;
        if (!hs) begin failures++; $display("FAIL arb_handshake: completed=0 required 1"); end
    endtask

    task automatic test_errors();
        bit ok, hs;
        logic [1:0] resp;
        logic [15:0] d;
        logic l;
        hs = 1'b1;
        ar_req(8'h00, 4'd1, 3'd2, BURST_INCR, ok); hs &= ok;
        for (int i = 0; i < 2; i++) begin
            r_take(d, resp, l, ok); hs &= ok;
            checks++;
            if (d !== 16'h0 || resp !== RESP_SLVERR)
                begin failures++; $display("FAIL wide_size_read beat %0d: data=%h resp=%0d required 0000 2", i, d, resp); end
        end
        ar_req(8'h80, 4'd0, 3'd1, BURST_INCR, ok); hs &= ok;
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'h0 || resp !== RESP_SLVERR || l !== 1'b1)
            begin failures++; $display("FAIL out_of_range_read: data=%h resp=%0d last=%b required 0000 2 1", d, resp, l); end
        ar_req(8'h00, 4'd2, 3'd1, BURST_WRAP, ok); hs &= ok;
        for (int i = 0; i < 3; i++) begin
            r_take(d, resp, l, ok); hs &= ok;
            checks++;
            if (resp !== RESP_SLVERR || d !== 16'h0)
                begin failures++; $display("FAIL wrap_len_read beat %0d: data=%h resp=%0d required 0000 2", i, d, resp); end
        end
        ar_req(8'h00, 4'd0, 3'd1, BURST_RSVD, ok); hs &= ok;
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL rsvd_burst_read: resp=%0d required 2", resp); end
        aw_req(8'h00, 4'd0, 3'd2, BURST_INCR, ok); hs &= ok;
        w_send(16'h0000, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        checks++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL wide_size_write: bresp=%0d required 2", resp); end
        ar_req(8'h00, 4'd0, 3'd1, BURST_INCR, ok); hs &= ok;
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'hff11 || resp !== RESP_OKAY)
            begin failures++; $display("FAIL err_write_no_modify: data=%h resp=%0d required ff11 0", d, resp); end
        aw_req(8'h20, 4'd1, 3'd1, BURST_INCR, ok); hs &= ok;
        w_send(16'h1234, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        checks++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL early_wlast: bresp=%0d required 2", resp); end
        aw_req(8'h21, 4'd0, 3'd0, BURST_INCR, ok); hs &= ok;
        w_send(16'h5a77, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        checks++;
        if (resp !== RESP_OKAY) begin failures++; $display("FAIL narrow_write_bresp: bresp=%0d required 0", resp); end
        ar_req(8'h20, 4'd0, 3'd1, BURST_INCR, ok); hs &= ok;
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'h5a34) begin failures++; $display("FAIL narrow_write_lane: data=%h required 5a34", d); end
        aw_req(8'h32, 4'd0, 3'd1, BURST_INCR, ok); hs &= ok;
        w_send(16'h7777, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        aw_req(8'h30, 4'd0, 3'd1, BURST_INCR, ok); hs &= ok;
        w_send(16'h1111, 2'b11, 1'b0, ok); hs &= ok;
        w_send(16'h2222, 2'b11, 1'b1, ok); hs &= ok;
        b_take(resp, ok); hs &= ok;
        checks++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL surplus_bresp: bresp=%0d required 2", resp); end
        ar_req(8'h30, 4'd1, 3'd1, BURST_INCR, ok); hs &= ok;
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'h1111) begin failures++; $display("FAIL surplus_first_word: data=%h required 1111", d); end
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'h7777) begin failures++; $display("FAIL surplus_discarded: data=%h required 7777", d); end
        checks++;
        if (!hs) begin failures++; $display("FAIL error_handshake: completed=0 required 1"); end
    endtask

    task automatic test_rready_stall();
        bit ok;
        ar_req(8'h00, 4'd3, 3'd1, BURST_INCR, ok);
        for (int i = 0; i < 6; i++) begin
            rready = STALL_R[i];
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== STALL_D[i] || rlast !== STALL_L[i])
                begin failures++; $display("FAIL stall cycle %0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                    i, rvalid, rdata, rlast, STALL_D[i], STALL_L[i]); end
            tick();
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || !ok)
            begin failures++; $display("FAIL stall_end: rvalid=%b ar_ok=%b required 0 1", rvalid, ok); end
    endtask

    task automatic test_reset_mid_write();
        bit ok, hs;
        logic [1:0] resp;
        logic [15:0] d;
        logic l;
        hs = 1'b1;
        aw_req(8'h40, 4'd3, 3'd1, BURST_INCR, ok); hs &= ok;
        w_send(16'ha1a1, 2'b11, 1'b0, ok); hs &= ok;
        w_send(16'hb2b2, 2'b11, 1'b0, ok); hs &= ok;
        res_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || dut.r_state !== ST_IDLE)
            begin failures++; $display("FAIL mid_write_reset: ctrl=%b state=%0d required 000000 IDLE",
                {awready, arready, wready, bvalid, rvalid, rlast}, dut.r_state); end
        tick();
        res_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b0)
            begin failures++; $display("FAIL mid_write_abandon: bvalid=%b awready=%b wready=%b required 0 1 0", bvalid, awready, wready); end
        ar_req(8'h40, 4'd1, 3'd1, BURST_INCR, ok); hs &= ok;
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'ha1a1) begin failures++; $display("FAIL retained_beat0: data=%h required a1a1", d); end
        r_take(d, resp, l, ok); hs &= ok;
        checks++;
        if (d !== 16'hb2b2) begin failures++; $display("FAIL retained_beat1: data=%h required b2b2", d); end
        checks++;
        if (!hs) begin failures++; $display("FAIL mid_write_handshake: completed=0 required 1"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr_write_read();
        test_wrap_fixed();
        test_arbitration();
        test_errors();
        test_rready_stall();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
